// File: rtl/life_ctrl.sv
// Player and goomba life-cycle controller: turns sticky collision death flags
// into death/respawn/invulnerability sequences, score, and collision clears.

package life_pkg;
  typedef enum logic [1:0] {
    P_ALIVE  = 2'd0,
    P_DYING  = 2'd1,
    P_INVULN = 2'd2,
    P_OUT    = 2'd3
  } pstate_t;

  typedef enum logic {
    G_IDLE     = 1'b0,
    G_SQUASHED = 1'b1
  } gstate_t;
endpackage

module life_player
  import life_pkg::*;
#(
  parameter int START_LIVES  = 3,
  parameter int DEATH_FRAMES = 60,
  parameter int INV_FRAMES   = 90
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       tick,
  input  logic       rise,
  output pstate_t    state,
  output logic [2:0] lives,
  output logic       respawn,
  output logic       expire
);
  logic [7:0] cnt;
  logic       death_done;

  assign death_done = (state == P_DYING) && tick && (cnt == 8'(DEATH_FRAMES - 1));
  // Only a death with a spare life respawns; the last life goes straight to OUT.
  assign expire     = death_done && (lives > 3'd1);

  // NOTE: every register here is sequential state, so it is written with <=
  // only; mixing in blocking writes would make read order matter.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state   <= P_ALIVE;
      lives   <= 3'(START_LIVES);
      cnt     <= 8'd0;
      respawn <= 1'b0;
    end else begin
      respawn <= expire;
      case (state)
        P_ALIVE: begin
          if (rise) begin
            state <= P_DYING;
            cnt   <= 8'd0;
          end
        end
        P_DYING: begin
          if (death_done) begin
            cnt <= 8'd0;
            if (lives > 3'd1) begin
              lives <= lives - 3'd1;
              state <= P_INVULN;
            end else begin
              lives <= 3'd0;
              state <= P_OUT;
            end
          end else if (tick) begin
            cnt <= cnt + 8'd1;
          end
        end
        P_INVULN: begin
          if (tick) begin
            if (cnt == 8'(INV_FRAMES - 1)) begin
              state <= P_ALIVE;
              cnt   <= 8'd0;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

module life_ctrl
  import life_pkg::*;
#(
  parameter int START_LIVES   = 3,
  parameter int DEATH_FRAMES  = 60,
  parameter int INV_FRAMES    = 90,
  parameter int SQUASH_FRAMES = 30,
  parameter int STOMP_POINTS  = 100
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_Clk,
  input  logic        mario_dead,
  input  logic        luigi_dead,
  input  logic        gomba_dead,
  output logic [2:0]  mario_lives,
  output logic [2:0]  luigi_lives,
  output logic [1:0]  mario_state,
  output logic [1:0]  luigi_state,
  output logic        mario_respawn,
  output logic        luigi_respawn,
  output logic        gomba_respawn,
  output logic        gomba_squashed,
  output logic        coll_clear,
  output logic [15:0] score,
  output logic        game_over
);
  logic [2:0]  fsync;
  logic        tick;
  logic [2:0]  dead_q;
  logic [2:0]  rise_q;
  pstate_t     m_state, l_state;
  logic        m_expire, l_expire, g_expire;
  gstate_t     g_state;
  logic [7:0]  g_cnt;
  logic [16:0] score_sum;

  // Two synchronizer flops, third flop only for edge detection.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      fsync  <= 3'b000;
      dead_q <= 3'b000;
      rise_q <= 3'b000;
    end else begin
      fsync  <= {fsync[1:0], frame_Clk};
      dead_q <= {gomba_dead, luigi_dead, mario_dead};
      rise_q <= {gomba_dead, luigi_dead, mario_dead} & ~dead_q;
    end
  end

  assign tick = fsync[1] & ~fsync[2];

  life_player #(
    .START_LIVES (START_LIVES),
    .DEATH_FRAMES(DEATH_FRAMES),
    .INV_FRAMES  (INV_FRAMES)
  ) u_mario (
    .Clk    (Clk),
    .Reset  (Reset),
    .tick   (tick),
    .rise   (rise_q[0]),
    .state  (m_state),
    .lives  (mario_lives),
    .respawn(mario_respawn),
    .expire (m_expire)
  );

  life_player #(
    .START_LIVES (START_LIVES),
    .DEATH_FRAMES(DEATH_FRAMES),
    .INV_FRAMES  (INV_FRAMES)
  ) u_luigi (
    .Clk    (Clk),
    .Reset  (Reset),
    .tick   (tick),
    .rise   (rise_q[1]),
    .state  (l_state),
    .lives  (luigi_lives),
    .respawn(luigi_respawn),
    .expire (l_expire)
  );

  assign mario_state    = m_state;
  assign luigi_state    = l_state;
  assign gomba_squashed = (g_state == G_SQUASHED);
  assign g_expire       = (g_state == G_SQUASHED) && tick && (g_cnt == 8'(SQUASH_FRAMES - 1));
  assign score_sum      = {1'b0, score} + 17'(STOMP_POINTS);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      g_state       <= G_IDLE;
      g_cnt         <= 8'd0;
      score         <= 16'd0;
      gomba_respawn <= 1'b0;
      coll_clear    <= 1'b0;
      game_over     <= 1'b0;
    end else begin
      gomba_respawn <= g_expire;
      // One shared pulse even when several timers expire on the same tick.
      coll_clear    <= m_expire | l_expire | g_expire;
      game_over     <= (m_state == P_OUT) && (l_state == P_OUT);
      case (g_state)
        G_IDLE: begin
          if (rise_q[2]) begin
            g_state <= G_SQUASHED;
            g_cnt   <= 8'd0;
            score   <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
          end
        end
        default: begin
          if (g_expire) begin
            g_state <= G_IDLE;
            g_cnt   <= 8'd0;
          end else if (tick) begin
            g_cnt <= g_cnt + 8'd1;
          end
        end
      endcase
    end
  end
endmodule

// File: doc/life_ctrl.md
Name: life_ctrl

Overview:
- Consumer of the collision block's sticky death flags (mario_dead, luigi_dead, gomba_dead).
- Turns each flag's rising edge into game consequences:
  - per-player death animation, lives decrement, respawn and invulnerability window;
  - goomba squash timing, goomba respawn and score.
- Drives coll_clear back to the collision block, so sticky flags are released after each respawn.
- Sits between collision and the sprite/HUD logic.

Parameters:
START_LIVES, 3, lives per player after reset (3-bit).
DEATH_FRAMES, 60, frames spent in DYING.
INV_FRAMES, 90, frames of invulnerability after respawn.
SQUASH_FRAMES, 30, frames goomba stays squashed before respawn.
STOMP_POINTS, 100, score added per goomba kill.

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-low reset
frame_Clk  in  1  vertical-sync frame clock, sampled as data in Clk domain
mario_dead  in  1  sticky death flag from collision
luigi_dead  in  1  sticky death flag from collision
gomba_dead  in  1  sticky goomba-dead flag from collision
mario_lives  out  3  remaining Mario lives
luigi_lives  out  3  remaining Luigi lives
mario_state  out  2  0 ALIVE, 1 DYING, 2 INVULN, 3 OUT
luigi_state  out  2  same encoding
mario_respawn  out  1  one-Clk pulse: reload Mario position
luigi_respawn  out  1  one-Clk pulse: reload Luigi position
gomba_respawn  out  1  one-Clk pulse: reload goomba position
gomba_squashed  out  1  high while goomba squash sprite is shown
coll_clear  out  1  one-Clk pulse: resets collision flags
score  out  16  accumulated points, saturating
game_over  out  1  high when both players are OUT

Behaviour:
- Reset low, asynchronous:
  - lives = START_LIVES;
  - states ALIVE;
  - all pulses 0, gomba_squashed 0, score 0, game_over 0;
  - all counters 0, synchronizer/edge registers 0.
- Frame tick: frame_Clk passes through a 2-flop synchronizer. tick = 1 for one Clk on the synchronized rising edge.
- Dead inputs are edge-detected in Clk; a rise means a fresh event. A level held high generates nothing further.
- Per-player FSM (Mario and Luigi identical, independent):
  - ALIVE: dead rise -> DYING, frame counter cleared.
  - DYING: counter++ on each tick. When counter == DEATH_FRAMES-1 on a tick:
    - if lives > 1: lives--, next cycle respawn=1 and coll_clear=1, state INVULN, counter cleared;
    - else: lives = 0, state OUT, no respawn.
  - INVULN: dead rises are ignored. After INV_FRAMES ticks -> ALIVE.
  - OUT: terminal until Reset.
- Counter/lives rules:
  - lives never underflows;
  - counters are 8-bit; parameters must be ≤ 255.
- Goomba FSM: IDLE -> SQUASHED on gomba_dead rise.
  - Same cycle: score += STOMP_POINTS, saturating at 16'hFFFF.
  - gomba_squashed = 1 in SQUASHED.
  - After SQUASH_FRAMES ticks: gomba_respawn=1 and coll_clear=1 for one cycle, then IDLE.
- coll_clear is the OR of all three respawn sources. Simultaneous sources produce a single one-cycle pulse.
- Simultaneous events:
  - both players may die in the same cycle; each FSM handles its own;
  - a goomba rise and a player rise in the same cycle are both taken.
- A goomba rise while SQUASHED is ignored and does not add score.
- game_over = (mario_state==OUT) && (luigi_state==OUT), registered, one cycle after the second OUT.
- Latency:
  - dead rise to state change: 2 Clk (edge register + state register);
  - respawn pulse: 1 Clk after the expiring tick.
- Reset mid-operation returns everything to reset values immediately, including an active pulse.

Test Plan:
1. Reset low, then release; no frame ticks -> lives 3/3, states 0, score 0, all pulses 0.
2. mario_dead rises and stays high; DEATH_FRAMES=4 -> DYING, then after 4 ticks one mario_respawn and one coll_clear; mario_lives 2; INVULN for INV_FRAMES ticks, then ALIVE; held level causes no second death.
3. Kill Luigi 3 times with full timing -> luigi_lives 2, 1, then 0; third death ends in OUT with no respawn; game_over stays 0 while Mario is ALIVE; kill Mario 3 times -> game_over 1.
4. gomba_dead rises while score=16'hFFC0 -> score 16'hFFFF (saturated); gomba_squashed for SQUASH_FRAMES ticks, then gomba_respawn and coll_clear pulses.
5. mario_dead and gomba_dead rise in the same cycle, and their timers expire on the same tick -> score +100, both FSMs advance, a single-cycle coll_clear.
6. Reset asserted low mid-DYING and mid-SQUASHED -> all outputs return to reset values asynchronously, with no spurious pulse after release.
